// File: rtl/uart_pkg.sv
// Shared constants for the UART transceiver: parity encodings, oversample
// ratio, sticky error bit positions and TX/RX FSM state codes.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int ERR_PARITY  = 0;
  localparam int ERR_START   = 1;
  localparam int ERR_STOP    = 2;
  localparam int ERR_OVERRUN = 3;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE   = 3'd0;
  localparam logic [2:0] RX_START  = 3'd1;
  localparam logic [2:0] RX_DATA   = 3'd2;
  localparam logic [2:0] RX_PARITY = 3'd3;
  localparam logic [2:0] RX_STOP   = 3'd4;

  // 2'b11 decodes as "no parity", same as PAR_NONE.
  function automatic logic par_en(input logic [1:0] p);
    return (p == PAR_ODD) || (p == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO. Extra pointer bit distinguishes
// full from empty; a push while full is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign count   = wptr - rptr;
  assign empty   = (wptr == rptr);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_transceiver_fifo.sv
// UART transceiver: shared 16x tick generator, valid/ready TX serialiser,
// oversampling RX deserialiser into a FWFT FIFO, loopback and sticky errors.
module uart_transceiver_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int RX_DEPTH  = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [DIV_WIDTH-1:0]        baud_div,
  input  logic [1:0]                  parity_type,
  input  logic                        stop2,
  input  logic                        loopback,
  input  logic                        tx_valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        tx_ready,
  output logic                        tx_out,
  output logic                        tx_active_flag,
  output logic                        tx_done_flag,
  input  logic                        rx_in,
  output logic                        rx_valid,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic [1:0]                  rx_frame_err,
  input  logic                        rx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        rx_active_flag,
  output logic [3:0]                  error_flag,
  input  logic                        err_clr
);

  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);
  localparam logic [TW-1:0]  T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]  T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(DATA_BITS - 1);

  // ---------------- tick generator ----------------
  logic [DIV_WIDTH-1:0] div_m1, bcnt;
  logic                 tick;

  assign div_m1 = (baud_div == '0) ? '0 : baud_div - 1'b1;
  // >= keeps the counter from running away if baud_div shrinks mid-count
  assign tick   = (bcnt >= div_m1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) bcnt <= '0;
    else          bcnt <= tick ? '0 : bcnt + 1'b1;
  end

  // ---------------- transmitter ----------------
  logic [2:0]           tx_st;
  logic [TW-1:0]        tx_tcnt;
  logic [BCW-1:0]       tx_bcnt;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par, tx_pen, tx_stop2, tx_scnt, tx_line;
  logic                 tx_bit_end, tx_accept;

  assign tx_bit_end     = tick && (tx_tcnt == T_LAST);
  assign tx_done_flag   = (tx_st == TX_STOP) && tx_bit_end && (!tx_stop2 || tx_scnt);
  assign tx_ready       = (tx_st == TX_IDLE) || tx_done_flag;
  assign tx_accept      = tx_valid && tx_ready;
  assign tx_active_flag = (tx_st != TX_IDLE);
  assign tx_out         = loopback ? 1'b1 : tx_line;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_st    <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_pen   <= 1'b0;
      tx_stop2 <= 1'b0;
      tx_scnt  <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      if (tick) tx_tcnt <= tx_tcnt + 1'b1;
      if (tx_accept) begin
        // accepting on the done cycle chains frames without an idle gap
        tx_st    <= TX_START;
        tx_tcnt  <= '0;
        tx_bcnt  <= '0;
        tx_sh    <= tx_data;
        tx_par   <= (^tx_data) ^ (parity_type == PAR_ODD);
        tx_pen   <= par_en(parity_type);
        tx_stop2 <= stop2;
        tx_scnt  <= 1'b0;
        tx_line  <= 1'b0;
      end else if (tx_bit_end) begin
        case (tx_st)
          TX_START: begin
            tx_st   <= TX_DATA;
            tx_line <= tx_sh[0];
          end
          TX_DATA: begin
            if (tx_bcnt == B_LAST) begin
              tx_st   <= tx_pen ? TX_PARITY : TX_STOP;
              tx_line <= tx_pen ? tx_par : 1'b1;
            end else begin
              tx_bcnt <= tx_bcnt + 1'b1;
              tx_sh   <= tx_sh >> 1;
              tx_line <= tx_sh[1];
            end
          end
          TX_PARITY: begin
            tx_st   <= TX_STOP;
            tx_line <= 1'b1;
          end
          TX_STOP: begin
            if (tx_stop2 && !tx_scnt) tx_scnt <= 1'b1;
            else                      tx_st   <= TX_IDLE;
          end
          default: tx_st <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- receiver front end ----------------
  logic rx_src, rx_m, rx_s;

  assign rx_src = loopback ? tx_line : rx_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_src;
      rx_s <= rx_m;
    end
  end

  // ---------------- receiver FSM ----------------
  logic [2:0]           rx_st;
  logic [TW-1:0]        rx_tcnt;
  logic [BCW-1:0]       rx_bcnt;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_pen, rx_podd, rx_stop2, rx_scnt, rx_perr, rx_serr;
  logic                 rx_sample, rx_push, rx_false, stop_bad;

  assign rx_sample      = tick && (rx_tcnt == ((rx_st == RX_START) ? T_MID : T_LAST));
  assign rx_push        = (rx_st == RX_STOP) && rx_sample && (!rx_stop2 || rx_scnt);
  assign rx_false       = (rx_st == RX_START) && rx_sample && rx_s;
  assign stop_bad       = rx_serr || !rx_s;
  assign rx_active_flag = (rx_st != RX_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_st    <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_sh    <= '0;
      rx_pen   <= 1'b0;
      rx_podd  <= 1'b0;
      rx_stop2 <= 1'b0;
      rx_scnt  <= 1'b0;
      rx_perr  <= 1'b0;
      rx_serr  <= 1'b0;
    end else begin
      if (tick) rx_tcnt <= rx_tcnt + 1'b1;
      case (rx_st)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_st    <= RX_START;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_pen   <= par_en(parity_type);
            rx_podd  <= (parity_type == PAR_ODD);
            rx_stop2 <= stop2;
            rx_scnt  <= 1'b0;
            rx_perr  <= 1'b0;
            rx_serr  <= 1'b0;
          end
        end
        RX_START: begin
          // realign so every later sample lands 16 ticks after the midpoint
          if (rx_sample) begin
            rx_tcnt <= '0;
            rx_st   <= rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_sh <= {rx_s, rx_sh[DATA_BITS-1:1]};
            if (rx_bcnt == B_LAST) rx_st   <= rx_pen ? RX_PARITY : RX_STOP;
            else                   rx_bcnt <= rx_bcnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_sample) begin
            rx_perr <= rx_s ^ (^rx_sh) ^ rx_podd;
            rx_st   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_sample) begin
            if (!rx_s) rx_serr <= 1'b1;
            if (rx_stop2 && !rx_scnt) rx_scnt <= 1'b1;
            else                      rx_st   <= RX_IDLE;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [DATA_BITS+1:0] fifo_head;
  logic                 fifo_full, fifo_empty, rx_pop;

  assign rx_pop = rx_valid && rx_ready;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (RX_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (rx_pop),
    .din     ({stop_bad, rx_perr, rx_sh}),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (rx_count)
  );

  assign rx_valid     = !fifo_empty;
  assign rx_data      = fifo_head[DATA_BITS-1:0];
  assign rx_frame_err = fifo_head[DATA_BITS+1:DATA_BITS];

  // ---------------- sticky errors ----------------
  logic [3:0] err_set;

  always_comb begin
    err_set              = '0;
    err_set[ERR_PARITY]  = rx_push && rx_perr;
    err_set[ERR_START]   = rx_false;
    err_set[ERR_STOP]    = rx_push && stop_bad;
    err_set[ERR_OVERRUN] = rx_push && fifo_full && !rx_pop;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) error_flag <= '0;
    else          error_flag <= (err_clr ? 4'b0 : error_flag) | err_set;
  end

endmodule

// File: tb/tb_uart_transceiver_fifo.sv
// Directed bench for uart_transceiver_fifo (RX_DEPTH=4): loopback, back-to-back,
// receive errors, overrun, two stop bits and asynchronous reset mid-frame.
module tb_uart_transceiver_fifo;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] baud_div;
  logic [1:0]  parity_type;
  logic        stop2, loopback, tx_valid, err_clr, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_ready, tx_out, tx_active_flag, tx_done_flag;
  logic        rx_in, rx_drv, rx_from_tx;
  logic        rx_valid, rx_active_flag;
  logic [7:0]  rx_data;
  logic [1:0]  rx_frame_err;
  logic [2:0]  rx_count;
  logic [3:0]  error_flag;

  int checks = 0;
  int errors = 0;

  assign rx_in = rx_from_tx ? tx_out : rx_drv;

  always #5 clock = ~clock;

  uart_transceiver_fifo #(.DATA_BITS(8), .RX_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .baud_div(baud_div), .parity_type(parity_type),
    .stop2(stop2), .loopback(loopback), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .tx_out(tx_out), .tx_active_flag(tx_active_flag),
    .tx_done_flag(tx_done_flag), .rx_in(rx_in), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_frame_err(rx_frame_err), .rx_ready(rx_ready), .rx_count(rx_count),
    .rx_active_flag(rx_active_flag), .error_flag(error_flag), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_tx(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clock);
    while (!tx_ready && n < 2000) begin @(negedge clock); n++; end
    chk("tx_ready_wait", {31'b0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clock); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int c;
    c = 0;
    @(negedge clock);
    while (int'(rx_count) < n && c < 3000) begin @(negedge clock); c++; end
    chk("wait_rx", {31'b0, int'(rx_count) >= n}, 32'd1);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] d, input logic [1:0] fe);
    @(negedge clock);
    chk({tag, "_valid"}, {31'b0, rx_valid}, 32'd1);
    chk({tag, "_data"}, {24'b0, rx_data}, {24'b0, d});
    chk({tag, "_ferr"}, {30'b0, rx_frame_err}, {30'b0, fe});
    rx_ready = 1'b1;
    @(posedge clock); #1;
    rx_ready = 1'b0;
  endtask

  // 16 cycles per bit at baud_div=1: start, 8 data LSB first, parity, stop
  task automatic ext_frame(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      rx_drv = bits[i];
      repeat (15) @(negedge clock);
    end
    @(negedge clock);
    rx_drv = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  task automatic pulse_clr();
    @(negedge clock); err_clr = 1'b1;
    @(negedge clock); err_clr = 1'b0;
  endtask

  initial begin
    int done_at, valid_at, bad, idx, viol, run;
    logic [7:0] w [3];

    reset_n = 1'b0; baud_div = 16'd1; parity_type = 2'b10; stop2 = 1'b0;
    loopback = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; err_clr = 1'b0;
    rx_ready = 1'b0; rx_drv = 1'b1; rx_from_tx = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_tx_out", {31'b0, tx_out}, 32'd1);
    chk("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_rx_count", {29'b0, rx_count}, 32'd0);
    chk("rst_err", {28'b0, error_flag}, 32'd0);
    reset_n = 1'b1;

    // ---- loopback round trip, baud_div=1, even parity ----
    loopback = 1'b1;
    repeat (2) @(negedge clock);
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(posedge clock); #1; tx_valid = 1'b0;
    done_at = 0; valid_at = 0; bad = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clock);
      if (tx_done_flag && done_at == 0) done_at = n;
      if (rx_valid && valid_at == 0) valid_at = n;
      if (tx_out !== 1'b1) bad++;
    end
    chk("lb_done_at", done_at, 32'd176);
    chk("lb_valid_in_time", {31'b0, valid_at > 0 && valid_at <= 175}, 32'd1);
    chk("lb_tx_out_high", bad, 32'd0);
    pop_chk("lb_a5", 8'hA5, 2'b00);

    // ---- back-to-back, tx_valid held, baud_div=3 ----
    baud_div = 16'd3;
    w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'h3C;
    idx = 0; viol = 0;
    @(negedge clock);
    tx_data = w[0]; tx_valid = 1'b1;
    for (int c = 0; c < 3000 && idx < 3; c++) begin
      if (idx > 0 && (tx_ready !== tx_done_flag || !tx_active_flag)) viol++;
      if (tx_ready) begin
        @(posedge clock); #1;
        idx++;
        if (idx < 3) tx_data = w[idx];
        else         tx_valid = 1'b0;
      end
      @(negedge clock);
    end
    chk("b2b_accepts", idx, 32'd3);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (tx_done_flag) break;
      if (tx_ready || !tx_active_flag) viol++;
    end
    chk("b2b_last_done", {31'b0, tx_done_flag}, 32'd1);
    chk("b2b_ready_active", viol, 32'd0);
    wait_rx(3);
    pop_chk("b2b_00", 8'h00, 2'b00);
    pop_chk("b2b_ff", 8'hFF, 2'b00);
    pop_chk("b2b_3c", 8'h3C, 2'b00);

    // ---- external receive errors, baud_div=1, even parity ----
    loopback = 1'b0; baud_div = 16'd1;
    repeat (4) @(negedge clock);
    ext_frame(8'h81, 1'b1, 1'b1);
    wait_rx(1);
    chk("perr_flag0", {31'b0, error_flag[0]}, 32'd1);
    pop_chk("perr_entry", 8'h81, 2'b01);
    ext_frame(8'h55, 1'b0, 1'b0);
    wait_rx(1);
    chk("serr_flag2", {31'b0, error_flag[2]}, 32'd1);
    pop_chk("serr_entry", 8'h55, 2'b10);
    pulse_clr();
    chk("clr_before_glitch", {28'b0, error_flag}, 32'd0);
    @(negedge clock); rx_drv = 1'b0;
    repeat (4) @(negedge clock); rx_drv = 1'b1;
    repeat (30) @(negedge clock);
    chk("glitch_no_entry", {29'b0, rx_count}, 32'd0);
    chk("glitch_flag", {28'b0, error_flag}, 32'd2);
    pulse_clr();
    chk("err_clr", {28'b0, error_flag}, 32'd0);

    // ---- overrun with depth 4 ----
    loopback = 1'b1;
    for (int k = 1; k <= 5; k++) send_tx(8'(k));
    repeat (200) @(negedge clock);
    chk("ovr_count", {29'b0, rx_count}, 32'd4);
    chk("ovr_flag3", {31'b0, error_flag[3]}, 32'd1);
    chk("ovr_head", {24'b0, rx_data}, 32'd1);
    pulse_clr();
    // frame 6: pop lands on the push edge (171 cycles after acceptance)
    @(negedge clock);
    tx_data = 8'h06; tx_valid = 1'b1;
    @(posedge clock); #1; tx_valid = 1'b0;
    repeat (170) @(posedge clock);
    #1 rx_ready = 1'b1;
    @(posedge clock); #1 rx_ready = 1'b0;
    repeat (10) @(negedge clock);
    chk("full_pushpop_count", {29'b0, rx_count}, 32'd4);
    chk("full_pushpop_noovr", {28'b0, error_flag}, 32'd0);
    pop_chk("ovr_2", 8'h02, 2'b00);
    pop_chk("ovr_3", 8'h03, 2'b00);
    pop_chk("ovr_4", 8'h04, 2'b00);

    // ---- two stop bits, baud_div=2, observed on tx_out ----
    repeat (20) @(negedge clock);
    loopback = 1'b0; rx_from_tx = 1'b1; baud_div = 16'd2; stop2 = 1'b1;
    send_tx(8'h33);
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (tx_out) run++; else run = 0;
      if (tx_done_flag) break;
    end
    chk("stop2_high_cycles", run, 32'd64);
    wait_rx(2);
    pop_chk("stop2_prev6", 8'h06, 2'b00);
    @(negedge clock);
    chk("stop2_rx_data", {24'b0, rx_data}, 32'h33);
    chk("stop2_rx_ferr", {30'b0, rx_frame_err}, 32'd0);

    // ---- asynchronous reset in the middle of a frame ----
    baud_div = 16'd1; stop2 = 1'b0;
    repeat (20) @(negedge clock);
    send_tx(8'h00);
    repeat (60) @(negedge clock);
    chk("mid_tx_out_low", {31'b0, tx_out}, 32'd0);
    chk("mid_tx_active", {31'b0, tx_active_flag}, 32'd1);
    chk("mid_rx_active", {31'b0, rx_active_flag}, 32'd1);
    chk("mid_rx_valid", {31'b0, rx_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_tx_out", {31'b0, tx_out}, 32'd1);
    chk("arst_tx_ready", {31'b0, tx_ready}, 32'd1);
    chk("arst_tx_active", {31'b0, tx_active_flag}, 32'd0);
    chk("arst_tx_done", {31'b0, tx_done_flag}, 32'd0);
    chk("arst_rx_active", {31'b0, rx_active_flag}, 32'd0);
    chk("arst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("arst_rx_count", {29'b0, rx_count}, 32'd0);
    chk("arst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("arst_err", {28'b0, error_flag}, 32'd0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1; loopback = 1'b1; rx_from_tx = 1'b0;
    send_tx(8'h5A);
    wait_rx(1);
    pop_chk("post_rst_5a", 8'h5A, 2'b00);
    chk("post_rst_err", {28'b0, error_flag}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
